switch_box_param: RTL and testbench
===================================

Name: switch_box_param

Overview:
- Parametrised CGRA routing switch box for any tile position.
- Each output track on each enabled side is a mux over the three other sides and the PE outputs.
- Each output has an optional per-track pipeline register with stall support.
- Configuration is double-buffered: addressed 32-bit word writes go to a shadow copy; a commit strobe applies them atomically to the active copy. Shadow words can be read back.

Parameters:
- NUM_TRACKS, 4, tracks per side (T), >=2
- WIDTH, 1, bits per track
- NUM_PE_OUTS, 1, PE outputs selectable as sources, 1..5
- OUT_SIDE_MASK, 4'b1001, bit s=1 means side s has driven outputs; others tie to 0
- ADDR_W, 4, config word address width; must satisfy 2**ADDR_W >= NUM_WORDS

Derived values:
- NSRC = 3 + NUM_PE_OUTS
- SEL_W = clog2(NSRC)
- F = SEL_W + 1
- CFG_BITS = 4*T*F
- NUM_WORDS = ceil(CFG_BITS/32)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_wire  in  4*T*WIDTH  side s track t at [(s*T+t)*WIDTH +: WIDTH]
- pe_output  in  NUM_PE_OUTS*WIDTH  PE output p at [p*WIDTH +: WIDTH]
- out_wire  out  4*T*WIDTH  same packing as in_wire
- stall  in  1  high: all pipeline registers hold their value
- cfg_we  in  1  write strobe for the shadow config
- cfg_addr  in  ADDR_W  config word index
- cfg_wdata  in  32  config write data
- cfg_commit  in  1  copy the whole shadow config into the active config
- cfg_rdata  out  32  registered readback of shadow word cfg_addr

Behaviour:
- Config field for output o = s*T+t sits at vector bits [o*F +: F].
  - bits [SEL_W-1:0] = sel
  - bit SEL_W = reg_en
- Vector word w = bits [32w +: 32]. Bits at or above CFG_BITS are not stored and read as 0.
- Source ordering: the three sides j != s in ascending j give sel 0,1,2.
  - Track used from side j = (t + ((j - s) mod 4) - 1) mod T.
  - sel 3+p selects pe_output p.
  - sel >= NSRC drives 0.
- Mux path is combinational from the active config only. Shadow contents never affect out_wire.
- reg_en=0: out_wire for that output = mux result, zero latency.
- reg_en=1: out_wire = a register loaded with the mux result each cycle when stall=0, held when stall=1 (1-cycle latency).
  - The register keeps updating while reg_en=0, so enabling it shows the previous cycle's mux value.
- Sides with OUT_SIDE_MASK[s]=0: outputs are constant 0. Their fields are still stored and readable, but no mux or register is built.
- Write: when cfg_we=1 and cfg_addr < NUM_WORDS, shadow word cfg_addr <= cfg_wdata (stored bits only). Writes with cfg_addr >= NUM_WORDS are ignored.
- Commit: when cfg_commit=1, active <= shadow as it was at the start of that cycle.
  - A same-cycle cfg_we updates the shadow only; it is not committed.
  - The new routing is visible on combinational outputs the cycle after commit.
- Readback: cfg_rdata <= shadow word cfg_addr every cycle, valid 1 cycle after the address is presented.
  - A same-cycle write returns the old value.
  - cfg_addr >= NUM_WORDS returns 0.
- Reset (any cycle, including mid-write or mid-commit):
  - shadow, active, pipeline registers and cfg_rdata all go to 0;
  - every output becomes bypassed sel 0;
  - reset takes priority over cfg_we, cfg_commit and stall.

Test Plan:
- Default routing (T=4, mask 4'b1001): reset, drive in_wire side1 track2 = 1 and all else 0 -> out_wire side0 track2 = 1 in the same cycle; sides 1 and 2 outputs = 0.
- Source ordering: write sel=2 for output side3 track0, commit -> out 3_0 follows in 2_2 (j=2, (0+3-1) mod 4 = 2). Write sel=3 -> out follows pe_output[0]. With NUM_PE_OUTS=4 and WIDTH=8: sel 6 follows pe_output[3], sel 7 drives 0.
- Shadow isolation: write a new sel without commit -> out_wire unchanged for 10 cycles. Assert cfg_commit -> change visible next cycle. cfg_we + cfg_commit on the same cycle to different values -> only the old shadow value takes effect.
- Pipelining: reg_en=1 on output 0_1 -> toggling its source shows up 1 cycle later. stall=1 for 3 cycles -> output frozen, then resumes the next cycle after stall drops.
- Readback/range: with T=4, F=3 (48 bits, 2 words), write 0xFFFFFFFF to word 1 -> readback 0x0000FFFF. Write to address 2 -> ignored; reading address 2 -> 0.
- Reset mid-operation: assert reset together with cfg_we and cfg_commit while registered outputs are 1 -> next cycle all outputs, the cfg_rdata register and the readback contents of every word = 0.

Source files
------------

// File: rtl/switch_box_param_if.sv
// Configuration bus for switch_box_param: shadow-word writes, commit strobe
// and registered readback of the addressed shadow word.
interface switch_box_param_if #(
  parameter int ADDR_W = 4
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [31:0]       cfg_wdata;
  logic              cfg_commit;
  logic [31:0]       cfg_rdata;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_rdata
  );
endinterface

// File: rtl/switch_box_param.sv
// CGRA routing switch box. Every output track on an enabled side selects
// one of the three other sides or a PE output, optionally through a
// stallable pipeline register. Routing comes from an active config copy
// that is loaded atomically from a word-addressed shadow copy.
module switch_box_param #(
  parameter int         NUM_TRACKS    = 4,
  parameter int         WIDTH         = 1,
  parameter int         NUM_PE_OUTS   = 1,
  parameter logic [3:0] OUT_SIDE_MASK = 4'b1001,
  parameter int         ADDR_W        = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_TRACKS*WIDTH-1:0] in_wire,
  input  logic [NUM_PE_OUTS*WIDTH-1:0]  pe_output,
  output logic [4*NUM_TRACKS*WIDTH-1:0] out_wire,
  input  logic                          stall,
  switch_box_param_if.slave             cfg
);

  localparam int T        = NUM_TRACKS;
  localparam int NSRC     = 3 + NUM_PE_OUTS;
  localparam int SEL_W    = $clog2(NSRC);
  localparam int F        = SEL_W + 1;
  localparam int CFG_BITS = 4 * T * F;

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] shadow_next;
  logic [31:0]         rd_word;

  // Word-addressed write merge and readback; bits past CFG_BITS do not
  // exist, so they are dropped on write and read back as zero, and
  // out-of-range addresses match no bit at all.
  always_comb begin
    shadow_next = shadow;
    rd_word     = '0;
    for (int unsigned b = 0; b < CFG_BITS; b++) begin
      if (cfg.cfg_addr == ADDR_W'(b / 32)) begin
        shadow_next[b]    = cfg.cfg_wdata[b % 32];
        rd_word[b % 32]   = shadow[b];
      end
    end
  end

  // Shadow config storage and registered readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow        <= '0;
      cfg.cfg_rdata <= '0;
    end else begin
      if (cfg.cfg_we) shadow <= shadow_next;
      cfg.cfg_rdata <= rd_word;
    end
  end

  for (genvar s = 0; s < 4; s++) begin : g_side
    for (genvar t = 0; t < T; t++) begin : g_trk
      localparam int O = s * T + t;

      if (OUT_SIDE_MASK[s]) begin : g_on
        logic [WIDTH-1:0] src [NSRC];
        logic [F-1:0]     act;
        logic [WIDTH-1:0] mux_val;
        logic [WIDTH-1:0] pipe;

        // Other sides in ascending order; the track offset makes each
        // neighbour contribute a distinct, rotated track.
        for (genvar k = 0; k < 3; k++) begin : g_src
          localparam int J  = (k < s) ? k : k + 1;
          localparam int D  = (J - s + 4) % 4;
          localparam int TR = (t + D - 1) % T;
          assign src[k] = in_wire[(J*T + TR)*WIDTH +: WIDTH];
        end
        for (genvar p = 0; p < NUM_PE_OUTS; p++) begin : g_pe
          assign src[3+p] = pe_output[p*WIDTH +: WIDTH];
        end

        // Active field for this output, loaded from the shadow on commit.
        always_ff @(posedge clk) begin
          if (reset)               act <= '0;
          else if (cfg.cfg_commit) act <= shadow[O*F +: F];
        end

        // Source select; unused select codes drive zero.
        always_comb begin
          mux_val = '0;
          for (int unsigned k = 0; k < NSRC; k++) begin
            if (act[SEL_W-1:0] == SEL_W'(k)) mux_val = src[k];
          end
        end

        // Pipeline register runs regardless of reg_en so enabling it
        // exposes the previous cycle's mux value.
        always_ff @(posedge clk) begin
          if (reset)       pipe <= '0;
          else if (!stall) pipe <= mux_val;
        end

        assign out_wire[O*WIDTH +: WIDTH] = act[SEL_W] ? pipe : mux_val;
      end else begin : g_off
        assign out_wire[O*WIDTH +: WIDTH] = '0;
      end
    end
  end

endmodule

// File: tb/tb_switch_box_param.sv
// Directed bench for switch_box_param: a default instance (T=4, WIDTH=1,
// one PE output) and a wide instance (WIDTH=8, four PE outputs).
module tb_switch_box_param;

  logic clk = 1'b0;
  logic reset;

  logic [15:0]  in1;
  logic         pe1;
  logic [15:0]  out1;
  logic         stall1;

  logic [127:0] in2;
  logic [31:0]  pe2;
  logic [127:0] out2;
  logic         stall2;

  int unsigned passed = 0;
  int unsigned total  = 0;

  switch_box_param_if #(.ADDR_W(4)) if1 ();
  switch_box_param_if #(.ADDR_W(4)) if2 ();

  switch_box_param #(
    .NUM_TRACKS(4), .WIDTH(1), .NUM_PE_OUTS(1),
    .OUT_SIDE_MASK(4'b1001), .ADDR_W(4)
  ) dut1 (
    .clk(clk), .reset(reset), .in_wire(in1), .pe_output(pe1),
    .out_wire(out1), .stall(stall1), .cfg(if1)
  );

  switch_box_param #(
    .NUM_TRACKS(4), .WIDTH(8), .NUM_PE_OUTS(4),
    .OUT_SIDE_MASK(4'b1001), .ADDR_W(4)
  ) dut2 (
    .clk(clk), .reset(reset), .in_wire(in2), .pe_output(pe2),
    .out_wire(out2), .stall(stall2), .cfg(if2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic c);
    if1.cfg_we = 1'b1; if1.cfg_addr = a; if1.cfg_wdata = d; if1.cfg_commit = c;
    tick();
    if1.cfg_we = 1'b0; if1.cfg_commit = 1'b0;
  endtask

  task automatic commit1();
    if1.cfg_commit = 1'b1;
    tick();
    if1.cfg_commit = 1'b0;
  endtask

  task automatic wr2(input logic [3:0] a, input logic [31:0] d);
    if2.cfg_we = 1'b1; if2.cfg_addr = a; if2.cfg_wdata = d;
    tick();
    if2.cfg_we = 1'b0;
    if2.cfg_commit = 1'b1;
    tick();
    if2.cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++;
    if (out1 !== 16'h0000) $display("FAIL reset_out1 got %h want 0000", out1);
    else passed++;
    total++;
    if (if1.cfg_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", if1.cfg_rdata);
    else passed++;
    total++;
    if (out2 !== 128'h0) $display("FAIL reset_out2 got %h want 0", out2);
    else passed++;
  endtask

  task automatic test_default_routing();
    in1 = 16'h0040; #1;
    total++;
    if (out1 !== 16'h0004) $display("FAIL default_s1t2 got %h want 0004", out1);
    else passed++;
    in1 = 16'h0F00; #1;
    total++;
    if (out1 !== 16'h0000) $display("FAIL default_side2 got %h want 0000", out1);
    else passed++;
    in1 = 16'h000F; #1;
    total++;
    if (out1 !== 16'hF000) $display("FAIL default_side0 got %h want f000", out1);
    else passed++;
    in1 = 16'h0000; #1;
  endtask

  task automatic test_source_order();
    wr1(4'd1, 32'h0000_0020, 1'b0);
    commit1();
    in1 = 16'h0400; #1;
    total++;
    if (out1[12] !== 1'b1) $display("FAIL sel2_high got %b want 1", out1[12]);
    else passed++;
    in1 = 16'hFBFF; #1;
    total++;
    if (out1[12] !== 1'b0) $display("FAIL sel2_low got %b want 0", out1[12]);
    else passed++;
    wr1(4'd1, 32'h0000_0030, 1'b0);
    commit1();
    in1 = 16'h0000; pe1 = 1'b1; #1;
    total++;
    if (out1[12] !== 1'b1) $display("FAIL sel3_pe_high got %b want 1", out1[12]);
    else passed++;
    in1 = 16'hFFFF; pe1 = 1'b0; #1;
    total++;
    if (out1[12] !== 1'b0) $display("FAIL sel3_pe_low got %b want 0", out1[12]);
    else passed++;
    in1 = 16'h0000;
    in2 = '1; pe2 = 32'hA533_2211;
    wr2(4'd1, 32'h0006_0000);
    total++;
    if (out2[103:96] !== 8'hA5) $display("FAIL sel6_pe3 got %h want a5", out2[103:96]);
    else passed++;
    wr2(4'd1, 32'h0007_0000);
    total++;
    if (out2[103:96] !== 8'h00) $display("FAIL sel7_zero got %h want 00", out2[103:96]);
    else passed++;
  endtask

  task automatic test_shadow_isolation();
    int unsigned bad;
    pe1 = 1'b1; in1 = 16'h0000;
    wr1(4'd1, 32'h0000_0020, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out1[12] !== 1'b1) bad++;
      tick();
    end
    total++;
    if (bad != 0) $display("FAIL shadow_isolated bad_cycles %0d want 0", bad);
    else passed++;
    commit1();
    total++;
    if (out1[12] !== 1'b0) $display("FAIL commit_visible got %b want 0", out1[12]);
    else passed++;
    wr1(4'd1, 32'h0000_0030, 1'b0);
    wr1(4'd1, 32'h0000_0000, 1'b1);
    total++;
    if (out1[12] !== 1'b1) $display("FAIL we_commit_same_cycle got %b want 1", out1[12]);
    else passed++;
    tick();
    total++;
    if (if1.cfg_rdata !== 32'h0) $display("FAIL we_commit_shadow got %h want 0", if1.cfg_rdata);
    else passed++;
    commit1();
    pe1 = 1'b0;
  endtask

  task automatic test_pipeline();
    int unsigned bad;
    in1 = 16'h0000;
    wr1(4'd0, 32'h0000_0020, 1'b0);
    commit1();
    total++;
    if (out1[1] !== 1'b0) $display("FAIL pipe_enable got %b want 0", out1[1]);
    else passed++;
    in1 = 16'h0020; #1;
    total++;
    if (out1[1] !== 1'b0) $display("FAIL pipe_latency_pre got %b want 0", out1[1]);
    else passed++;
    tick();
    total++;
    if (out1[1] !== 1'b1) $display("FAIL pipe_rise got %b want 1", out1[1]);
    else passed++;
    in1 = 16'h0000; #1;
    total++;
    if (out1[1] !== 1'b1) $display("FAIL pipe_hold_pre got %b want 1", out1[1]);
    else passed++;
    tick();
    total++;
    if (out1[1] !== 1'b0) $display("FAIL pipe_fall got %b want 0", out1[1]);
    else passed++;
    in1 = 16'h0020; stall1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out1[1] !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL stall_frozen bad_cycles %0d want 0", bad);
    else passed++;
    stall1 = 1'b0; #1;
    total++;
    if (out1[1] !== 1'b0) $display("FAIL stall_release_pre got %b want 0", out1[1]);
    else passed++;
    tick();
    total++;
    if (out1[1] !== 1'b1) $display("FAIL stall_resume got %b want 1", out1[1]);
    else passed++;
  endtask

  task automatic test_readback();
    wr1(4'd1, 32'h0000_0012, 1'b0);
    wr1(4'd1, 32'hFFFF_FFFF, 1'b0);
    total++;
    if (if1.cfg_rdata !== 32'h0000_0012) $display("FAIL rd_same_cycle_old got %h want 00000012", if1.cfg_rdata);
    else passed++;
    tick();
    total++;
    if (if1.cfg_rdata !== 32'h0000_FFFF) $display("FAIL rd_word1_trunc got %h want 0000ffff", if1.cfg_rdata);
    else passed++;
    wr1(4'd2, 32'hDEAD_BEEF, 1'b0);
    tick();
    total++;
    if (if1.cfg_rdata !== 32'h0) $display("FAIL rd_addr2 got %h want 0", if1.cfg_rdata);
    else passed++;
    if1.cfg_addr = 4'd0;
    tick();
    total++;
    if (if1.cfg_rdata !== 32'h0000_0020) $display("FAIL rd_word0_intact got %h want 00000020", if1.cfg_rdata);
    else passed++;
    if1.cfg_addr = 4'd1;
    tick();
    total++;
    if (if1.cfg_rdata !== 32'h0000_FFFF) $display("FAIL rd_word1_intact got %h want 0000ffff", if1.cfg_rdata);
    else passed++;
  endtask

  task automatic test_reset_mid();
    in1 = 16'h0020; stall1 = 1'b0;
    tick(); tick();
    total++;
    if (out1[1] !== 1'b1) $display("FAIL pre_reset_reg got %b want 1", out1[1]);
    else passed++;
    reset = 1'b1; stall1 = 1'b1;
    if1.cfg_we = 1'b1; if1.cfg_addr = 4'd0; if1.cfg_wdata = 32'hFFFF_FFFF; if1.cfg_commit = 1'b1;
    tick();
    reset = 1'b0; if1.cfg_we = 1'b0; if1.cfg_commit = 1'b0;
    in1 = 16'h0000; #1;
    total++;
    if (out1 !== 16'h0000) $display("FAIL mid_reset_out got %h want 0000", out1);
    else passed++;
    total++;
    if (if1.cfg_rdata !== 32'h0) $display("FAIL mid_reset_rdata got %h want 0", if1.cfg_rdata);
    else passed++;
    tick();
    total++;
    if (if1.cfg_rdata !== 32'h0) $display("FAIL mid_reset_word0 got %h want 0", if1.cfg_rdata);
    else passed++;
    if1.cfg_addr = 4'd1;
    tick();
    total++;
    if (if1.cfg_rdata !== 32'h0) $display("FAIL mid_reset_word1 got %h want 0", if1.cfg_rdata);
    else passed++;
    in1 = 16'h0020; #1;
    total++;
    if (out1 !== 16'h0002) $display("FAIL mid_reset_bypass got %h want 0002", out1);
    else passed++;
    wr1(4'd0, 32'h0000_0020, 1'b0);
    commit1();
    total++;
    if (out1[1] !== 1'b0) $display("FAIL mid_reset_pipe got %b want 0", out1[1]);
    else passed++;
    stall1 = 1'b0;
    tick();
    total++;
    if (out1[1] !== 1'b1) $display("FAIL post_reset_pipe got %b want 1", out1[1]);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in1 = '0; pe1 = 1'b0; stall1 = 1'b0;
    in2 = '0; pe2 = '0;   stall2 = 1'b0;
    if1.cfg_we = 1'b0; if1.cfg_addr = '0; if1.cfg_wdata = '0; if1.cfg_commit = 1'b0;
    if2.cfg_we = 1'b0; if2.cfg_addr = '0; if2.cfg_wdata = '0; if2.cfg_commit = 1'b0;
    test_reset();
    test_default_routing();
    test_source_order();
    test_shadow_isolation();
    test_pipeline();
    test_readback();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
